pipe_issue: RTL and testbench

- Instruction issue stage directly upstream of the 4-stage pipelined ALU.
- Buffers 24-bit instruction words from a loader in a FIFO and decodes them into the ALU's rs1/rs2/rd/func/addr fields.
- Issues at most one instruction per cycle.
- Inserts bubbles on read-after-write hazards against in-flight destinations, and stops on a HALT opcode.

---
 rtl/pipe_pkg.sv | 48 ++++
 rtl/pipe_issue_fifo.sv | 59 +++++
 rtl/pipe_issue.sv | 140 ++++++++++++++
 tb/tb_pipe_issue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg                                                           |
// | Shared opcodes, instruction layout, bubble encoding, FSM states.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pipe_pkg;

    localparam int INSTR_W  = 24;
    localparam int FUNC_LSB = 20;
    localparam int RS1_LSB  = 16;
    localparam int RS2_LSB  = 12;
    localparam int RD_LSB   = 8;
    localparam int ADDR_LSB = 0;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_PASSA = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_INC   = 4'd7;
    localparam logic [3:0] OP_DEC   = 4'd8;
    localparam logic [3:0] OP_LD    = 4'd9;
    localparam logic [3:0] OP_ST    = 4'd10;
    localparam logic [3:0] OP_SHL   = 4'd11;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // A bubble copies regbank[0] onto itself, so it has no architectural effect
    localparam logic [3:0] BUB_FUNC = OP_PASSA;
    localparam logic [3:0] BUB_REG  = 4'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Field order matches the bit offsets above (func in the top nibble)
    typedef struct packed {
        logic [3:0] func;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [7:0] addr;
    } instr_t;

endpackage
`default_nettype wire

// File: rtl/pipe_issue_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_issue_fifo                                                    |
// | Synchronous FIFO with combinational head read and occupancy count. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_issue_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int                  c_ADDR_W   = $clog2(DEPTH);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);
    localparam logic [c_ADDR_W:0]   c_LVL_ONE  = (c_ADDR_W + 1)'(1);
    localparam logic [c_ADDR_W:0]   c_LVL_FULL = (c_ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_level;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({push, pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = (r_level == c_LVL_FULL);
    assign empty = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/pipe_issue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_issue                                                         |
// | Issue stage: FIFO, RAW hazard bubbles and HALT handling for ALU.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_issue
    import pipe_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter int         HAZ_WIN  = 3,
    parameter logic [7:0] BUB_ADDR = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [23:0]              in_instr,
    output logic                     in_ready,
    input  logic                     go,
    input  logic                     resume,
    output logic [3:0]               func,
    output logic [3:0]               rs1,
    output logic [3:0]               rs2,
    output logic [3:0]               rd,
    output logic [7:0]               addr,
    output logic                     issue_valid,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              stall_cnt
);

    logic [23:0]        w_head_word;
    instr_t             w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic               w_halt_pop;
    logic               w_stall;
    logic               w_hazard;
    logic [HAZ_WIN-1:0] w_match;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [HAZ_WIN-1:0] r_win_vld;
    logic [3:0]         r_win_rd [HAZ_WIN];
    instr_t             r_out;
    logic               r_issue_valid;
    logic               r_halted;
    logic [15:0]        r_stall_cnt;

    pipe_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_instr),
        .rdata (w_head_word),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_head = instr_t'(w_head_word);

    for (genvar g = 0; g < HAZ_WIN; g++) begin : g_haz
        assign w_match[g] = r_win_vld[g] &&
                            ((r_win_rd[g] == w_head.rs1) || (r_win_rd[g] == w_head.rs2));
    end
    assign w_hazard = |w_match;

    // HALT at the head takes priority over any hazard it might raise
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_halt_pop  = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: if (go) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!w_empty) begin
                    if (w_head.func == OP_HALT) begin
                        w_halt_pop  = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else if (w_hazard) begin
                        w_stall = 1'b1;
                    end else begin
                        w_issue = 1'b1;
                    end
                end
            end
            ST_HALT: if (resume) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pop depends only on registered state, so in_ready never loops back from in_valid
    assign w_pop    = w_issue | w_halt_pop;
    assign in_ready = !w_full || w_pop;
    assign w_push   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_halted      <= 1'b0;
            r_issue_valid <= 1'b0;
            r_out         <= '{func: BUB_FUNC, rs1: BUB_REG, rs2: BUB_REG, rd: BUB_REG, addr: BUB_ADDR};
            r_stall_cnt   <= '0;
            r_win_vld     <= '0;
            for (int i = 0; i < HAZ_WIN; i++) r_win_rd[i] <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_halted      <= (w_state_nxt == ST_HALT);
            r_issue_valid <= w_issue;
            if (w_issue) r_out <= w_head;
            else         r_out <= '{func: BUB_FUNC, rs1: BUB_REG, rs2: BUB_REG, rd: BUB_REG, addr: BUB_ADDR};
            if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
            for (int i = HAZ_WIN - 1; i > 0; i--) begin
                r_win_vld[i] <= r_win_vld[i-1];
                r_win_rd[i]  <= r_win_rd[i-1];
            end
            r_win_vld[0] <= w_issue;
            r_win_rd[0]  <= w_head.rd;
        end
    end

    assign func        = r_out.func;
    assign rs1         = r_out.rs1;
    assign rs2         = r_out.rs2;
    assign rd          = r_out.rd;
    assign addr        = r_out.addr;
    assign issue_valid = r_issue_valid;
    assign halted      = r_halted;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_issue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_issue                                                      |
// | Directed vectors with hand-computed expectations for pipe_issue.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pipe_issue;

    localparam logic [23:0] c_BUBBLE = 24'h3000FF;
    localparam int          c_N_SAT  = 21847;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] in_instr;
    logic        in_ready;
    logic        go;
    logic        resume;
    logic [3:0]  func;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [7:0]  addr;
    logic        issue_valid;
    logic        halted;
    logic [3:0]  level;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_issue #(
        .DEPTH    (8),
        .HAZ_WIN  (3),
        .BUB_ADDR (8'hFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .go          (go),
        .resume      (resume),
        .func        (func),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .addr        (addr),
        .issue_valid (issue_valid),
        .halted      (halted),
        .level       (level),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [23:0] word, input logic vld);
        chk({tag, "_word"}, 32'({func, rs1, rs2, rd, addr}), 32'(word));
        chk({tag, "_vld"}, 32'(issue_valid), 32'(vld));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Independent words for the full-FIFO test: rs = E never matches rd 1..9
    function automatic logic [23:0] w3(input int i);
        return {4'(i), 4'hE, 4'hE, 4'(i + 1), 8'h30 + 8'(i)};
    endfunction

    initial begin
        int pushed;
        int issued;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; go = 1'b0; resume = 1'b0;
        step();
        chk_out("rst", c_BUBBLE, 1'b0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        rst_n = 1'b1;
        step();

        // 1: three independent words issue back to back
        go = 1'b1; step(); go = 1'b0;
        in_valid = 1'b1; in_instr = 24'h02310A; step();
        in_instr = 24'h15640B; step(); chk_out("t1_add", 24'h02310A, 1'b1);
        in_instr = 24'h48970C; step(); chk_out("t1_sub", 24'h15640B, 1'b1);
        in_valid = 1'b0;       step(); chk_out("t1_or",  24'h48970C, 1'b1);
        step(); chk_out("t1_empty", c_BUBBLE, 1'b0);
        chk("t1_stall", 32'(stall_cnt), 0);

        // 2: RAW on r5 costs exactly three bubbles
        step(); step(); step();
        in_valid = 1'b1; in_instr = 24'h012520; step();
        in_instr = 24'h553621; step(); chk_out("t2_add", 24'h012520, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out($sformatf("t2_bub%0d", i), c_BUBBLE, 1'b0);
        end
        step(); chk_out("t2_xor", 24'h553621, 1'b1);
        chk("t2_stall", 32'(stall_cnt), 3);

        // 3: fill in IDLE, then push while full and popping
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = w3(i); step();
        end
        chk("t3_full_level", 32'(level), 8);
        chk("t3_full_ready", 32'(in_ready), 0);
        go = 1'b1; in_instr = w3(8); step(); go = 1'b0;
        chk("t3_idle_block", 32'(level), 8);
        chk("t3_ready_pop", 32'(in_ready), 1);
        step();
        chk_out("t3_w0", w3(0), 1'b1);
        chk("t3_level_swap", 32'(level), 8);
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(); chk_out($sformatf("t3_w%0d", i), w3(i), 1'b1);
        end

        // 4: HALT is swallowed, go ignored, resume releases SUB
        step(); step(); step();
        in_valid = 1'b1; in_instr = 24'h012340; step();
        in_instr = 24'hF00000; step(); chk_out("t4_add", 24'h012340, 1'b1);
        in_instr = 24'h145641; step(); chk_out("t4_halt", c_BUBBLE, 1'b0);
        chk("t4_halted", 32'(halted), 1);
        in_valid = 1'b0; go = 1'b1; step(); go = 1'b0;
        chk("t4_go_ignored", 32'(halted), 1);
        chk("t4_wait_level", 32'(level), 1);
        chk_out("t4_wait", c_BUBBLE, 1'b0);
        resume = 1'b1; step(); resume = 1'b0;
        chk("t4_resumed", 32'(halted), 0);
        chk_out("t4_res_bub", c_BUBBLE, 1'b0);
        step(); chk_out("t4_sub", 24'h145641, 1'b1);

        // 5: async reset with four words queued behind a HALT
        step();
        in_valid = 1'b1; in_instr = 24'hF00000; step();
        in_instr = 24'h0AB150; step();
        in_instr = 24'h0AB251; step();
        in_instr = 24'h0AB352; step();
        in_instr = 24'h0AB453; step();
        in_valid = 1'b0;
        chk("t5_level4", 32'(level), 4);
        chk("t5_halted", 32'(halted), 1);
        rst_n = 1'b0; #1;
        chk("t5_rst_level", 32'(level), 0);
        chk("t5_rst_ready", 32'(in_ready), 1);
        chk("t5_rst_halted", 32'(halted), 0);
        chk_out("t5_rst", c_BUBBLE, 1'b0);
        step(); rst_n = 1'b1; step();
        go = 1'b1; step(); go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t5_stale%0d", i), 32'(issue_valid), 0);
        end
        chk("t5_post_level", 32'(level), 0);

        // 6: dependent chain r1 <- r1 drives stall_cnt into saturation
        pushed = 0; issued = 0; cyc = 0;
        in_instr = 24'h011100;
        while ((pushed < c_N_SAT || issued < c_N_SAT) && cyc < 90000) begin
            in_valid = (pushed < c_N_SAT);
            if (in_valid && in_ready) pushed++;
            step();
            cyc++;
            if (issue_valid) begin
                issued++;
                if (issued == 100) chk("t6_mid_stall", 32'(stall_cnt), 297);
            end
        end
        in_valid = 1'b0;
        chk("t6_issued", 32'(issued), 32'(c_N_SAT));
        chk("t6_saturated", 32'(stall_cnt), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
